// File: rtl/vga_fb_arbiter_pkg.sv
// Shared frame-buffer geometry and arbiter slot encoding for the VGA scan-out path.
package vga_fb_arbiter_pkg;
    localparam int H_VISIBLE = 640;
    localparam int H_TOTAL   = 800;
    localparam int V_VISIBLE = 480;
    localparam int V_TOTAL   = 525;
    localparam int FB_ADDR_W = 19;
    localparam int FB_DATA_W = 8;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_READ,
        SLOT_WRITE
    } slot_e;
endpackage

// File: rtl/vga_fb_arbiter_fifo_sync.sv
// Small synchronous FIFO holding posted pixel writes; head entry is visible combinationally.
module fifo_sync #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             i_sclr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [LW-1:0]    o_level,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             push_ok, pop_ok;

    assign o_full  = (o_level == LW'(DEPTH));
    assign o_empty = (o_level == '0);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_rdata = mem[rd_ptr];

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   o_level <= o_level + LW'(1);
                2'b01:   o_level <= o_level - LW'(1);
                default: o_level <= o_level;
            endcase
        end
    end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: scan-out reads always win, posted writes drain into free slots.
module vga_fb_arbiter
    import vga_fb_arbiter_pkg::*;
#(
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int DATA_W       = FB_DATA_W,
    parameter int WQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 1024,
    localparam int LW = $clog2(WQ_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              i_sclr,
    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic              o_disp_valid,
    output logic [DATA_W-1:0] o_disp_data,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [LW-1:0]     o_wq_level,
    output logic              o_starve
);
    localparam int CW     = $clog2(STARVE_LIMIT + 1);
    localparam int STAGES = 2;

    slot_e                    slot;
    logic                     push, pop, wq_full, wq_empty;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;
    logic [STAGES:0]          vld_pipe;
    logic [CW-1:0]            starve_cnt;

    always_comb begin
        slot = SLOT_IDLE;
        if (i_disp_req)
            slot = SLOT_READ;
        else if (!wq_empty)
            slot = SLOT_WRITE;
    end

    assign o_wr_ready = (o_wq_level < LW'(WQ_DEPTH));
    assign push       = i_wr_valid && o_wr_ready && !i_sclr;
    assign pop        = (slot == SLOT_WRITE) && !i_sclr;

    fifo_sync #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (WQ_DEPTH)
    ) u_wq (
        .clk     (clk),
        .i_sclr  (i_sclr),
        .i_push  (push),
        .i_wdata ({i_wr_addr, i_wr_data}),
        .i_pop   (pop),
        .o_rdata ({head_addr, head_data}),
        .o_level (o_wq_level),
        .o_full  (wq_full),
        .o_empty (wq_empty)
    );

    // Idle slots keep the last address/data so the RAM bus does not toggle.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            case (slot)
                SLOT_READ: begin
                    o_mem_en   <= 1'b1;
                    o_mem_we   <= 1'b0;
                    o_mem_addr <= i_disp_addr;
                end
                SLOT_WRITE: begin
                    o_mem_en    <= 1'b1;
                    o_mem_we    <= 1'b1;
                    o_mem_addr  <= head_addr;
                    o_mem_wdata <= head_data;
                end
                default: begin
                    o_mem_en <= 1'b0;
                    o_mem_we <= 1'b0;
                end
            endcase
        end
    end

    // [0] command on bus, [1] RAM data present, [2] data registered out.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            vld_pipe    <= '0;
            o_disp_data <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], slot == SLOT_READ};
            if (vld_pipe[STAGES-1])
                o_disp_data <= i_mem_rdata;
        end
    end

    assign o_disp_valid = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            starve_cnt <= '0;
            o_starve   <= 1'b0;
        end else if (wq_full && !pop) begin
            if (starve_cnt != CW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + CW'(1);
            if (starve_cnt >= CW'(STARVE_LIMIT - 1))
                o_starve <= 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end
endmodule
